// File: rtl/hex_display_pkg.sv
// Shared types and code constants for the hex display controller.
package hex_display_pkg;

    typedef logic [3:0] bcd_code_t;

    localparam bcd_code_t BCD_UNDERSCORE = 4'hA;
    localparam bcd_code_t BCD_CLEAR      = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } flash_state_t;

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Write-request bus for the two arbitrated requesters (A has priority over B).
interface hex_display_ctrl_if;
    import hex_display_pkg::*;

    logic      a_req;
    logic [2:0] a_idx;
    bcd_code_t a_code;
    logic      a_gnt;

    logic      b_req;
    logic [2:0] b_idx;
    bcd_code_t b_code;
    logic      b_gnt;

    modport master (
        output a_req, a_idx, a_code,
        output b_req, b_idx, b_code,
        input  a_gnt, b_gnt
    );

    modport slave (
        input  a_req, a_idx, a_code,
        input  b_req, b_idx, b_code,
        output a_gnt, b_gnt
    );

endinterface

// File: rtl/hex_tick_gen.sv
// Free-running 0..BLINK_DIV-1 counter; tick is high for the last count of each period.
module hex_tick_gen #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        if (restart || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/hex_display_ctrl.sv
// Stored digit codes with arbitrated writes, shift entry, cursor blink and flash sequence.
// Build option: HEX_DISPLAY_CTRL_UNDERSCORE_CURSOR_EN selects underscore as the cursor code.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int BLINK_DIV   = 25000000,
    parameter int FLASH_COUNT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_all,
    input  logic                    shift_valid,
    input  bcd_code_t               shift_code,
    hex_display_ctrl_if.slave       wr,
    input  logic                    cursor_en,
    input  logic [2:0]              cursor_idx,
    input  logic                    flash_start,
    output logic                    flash_busy,
    output logic [NUM_DIGITS*4-1:0] digit_codes
);

`ifdef HEX_DISPLAY_CTRL_UNDERSCORE_CURSOR_EN
    localparam bcd_code_t CURSOR_CODE = BCD_UNDERSCORE;
`else
    localparam bcd_code_t CURSOR_CODE = BCD_CLEAR;
`endif

    localparam int REM_W = $clog2(FLASH_COUNT + 1);

    bcd_code_t    digit_q [NUM_DIGITS];
    bcd_code_t    digit_d [NUM_DIGITS];
    flash_state_t state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic         phase_q, phase_d;
    logic         a_gnt, b_gnt;
    logic         tick;
    logic         flash_accept;
    logic         blank_all;

    assign a_gnt    = wr.a_req & ~clr_all & ~shift_valid;
    assign b_gnt    = wr.b_req & ~a_gnt & ~clr_all & ~shift_valid;
    assign wr.a_gnt = a_gnt;
    assign wr.b_gnt = b_gnt;

    hex_tick_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (flash_accept),
        .tick    (tick)
    );

    // Out-of-range indices match no digit, so those writes are dropped.
    always_comb begin
        digit_d = digit_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (clr_all) begin
                digit_d[i] = BCD_CLEAR;
            end else if (shift_valid) begin
                digit_d[i] = (i == 0) ? shift_code : digit_q[(i > 0) ? i - 1 : 0];
            end else if (a_gnt) begin
                if (wr.a_idx == 3'(i)) digit_d[i] = wr.a_code;
            end else if (b_gnt) begin
                if (wr.b_idx == 3'(i)) digit_d[i] = wr.b_code;
            end
        end
    end

    always_comb begin
        phase_d = 1'b0;
        if (cursor_en) begin
            phase_d = tick ? ~phase_q : phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= BCD_CLEAR;
            end
            phase_q <= 1'b0;
        end else begin
            digit_q <= digit_d;
            phase_q <= phase_d;
        end
    end

    // Flash FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Flash FSM: next state; each BLANK/SHOW half lasts one tick period.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (flash_start) begin
                    state_d = BLANK;
                    rem_d   = REM_W'(FLASH_COUNT);
                end
            end
            BLANK: begin
                if (tick) state_d = SHOW;
            end
            SHOW: begin
                if (tick) begin
                    if (rem_q == REM_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        rem_d   = rem_q - REM_W'(1);
                        state_d = BLANK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flash FSM: outputs.
    always_comb begin
        flash_busy   = (state_q != IDLE);
        blank_all    = (state_q == BLANK);
        flash_accept = (state_q == IDLE) && flash_start;
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_out
        logic cursor_on;
        assign cursor_on = phase_q && !flash_busy && (cursor_idx == 3'(gi));
        assign digit_codes[4*gi +: 4] = blank_all ? BCD_CLEAR :
                                        cursor_on ? CURSOR_CODE : digit_q[gi];
    end

endmodule
